// File: rtl/mux16_scan.sv
// mux16_scan: 16-to-1 event collector, round-robin serializer to (f, s).
// Optional sticky per-channel overflow flags: define MUX16_OVERFLOW_EN.
module mux16_scan #(
    parameter int LEVEL = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] y,
    input  logic        ready,
    output logic        f,
    output logic [3:0]  s,
    output logic [15:0] pend
`ifdef MUX16_OVERFLOW_EN
    ,
    output logic [15:0] ovf
`endif
);

    logic [15:0] y_q;
    logic [15:0] ev;
    logic [15:0] gnt_oh;
    logic [15:0] pend_nxt;
    logic [3:0]  ptr;
    logic [3:0]  gnt_idx;
    logic [3:0]  probe;
    logic        gnt_found;
    logic        load;

    // Output register is free when empty or being accepted this cycle.
    assign load = ~f | ready;

    // Event detect: rising edge or level, depending on LEVEL.
    always_comb begin
        ev = y & ~y_q;
        if (LEVEL != 0) begin
            ev = y;
        end
    end

    // Round-robin search of pending bits starting at ptr, wrapping 15->0.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = ptr;
        probe     = ptr;
        for (int i = 0; i < 16; i++) begin
            probe = ptr + 4'(i);
            if (!gnt_found && pend[probe]) begin
                gnt_found = 1'b1;
                gnt_idx   = probe;
            end
        end
    end

    // One-hot clear mask; new events override the clear on the same channel.
    always_comb begin
        gnt_oh = '0;
        if (load && gnt_found) begin
            gnt_oh[gnt_idx] = 1'b1;
        end
        pend_nxt = (pend & ~gnt_oh) | ev;
    end

    // Edge history, pending set, pointer and output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            y_q  <= '0;
            pend <= '0;
            ptr  <= '0;
            f    <= 1'b0;
            s    <= '0;
        end else begin
            y_q  <= y;
            pend <= pend_nxt;
            if (load) begin
                if (gnt_found) begin
                    f   <= 1'b1;
                    s   <= gnt_idx;
                    ptr <= gnt_idx + 4'd1;
                end else begin
                    f <= 1'b0;
                end
            end
        end
    end

`ifdef MUX16_OVERFLOW_EN
    // Sticky flag: an event landed on a bit that stays pending, so one is lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf <= '0;
        end else begin
            ovf <= ovf | (ev & pend & ~gnt_oh);
        end
    end
`endif

endmodule
